pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage RISC-V-lite pipeline. It generates the per-stage pipeline enables (`pipe_en` of each stage register bank), the bubble/flush strobes, and the EX-stage `forwardA`/`forwardB` selects. It detects load-use and RAW hazards, sequences taken-branch flushes and data-memory wait freezes, and holds the pipeline quiet for a fixed number of cycles after reset. It sits beside the datapath and only produces control.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 45 ++++
 rtl/pipeline_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the five-stage pipeline controller.
//   ctrl_state_t : controller FSM state (HOLD, RUN, MEM_WAIT)
//   FWD_*        : EX-stage operand forward-select encodings
//   fwd_sel()    : forward-select for one EX source register
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // The younger producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Combinational matching of the ID-stage source registers against the
// destinations of the instructions in EX and MEM.
//   id_rs1_i, id_rs2_i         : ID source registers
//   id_use_rs1_i, id_use_rs2_i : ID instruction really reads that source
//   ex_rd_i, ex_regwrite_i     : EX destination and write flag
//   ex_memread_i               : EX instruction is a load
//   mem_rd_i, mem_regwrite_i   : MEM destination and write flag
//   ex_hit_o                   : a used ID source matches a writing, nonzero ex_rd
//   mem_hit_o                  : a used ID source matches a writing, nonzero mem_rd
//   load_use_o                 : ex_hit_o caused by a load
// ----------------------------------------------------------------------------
module hazard_detect (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_regwrite_i,
    input  logic       ex_memread_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_regwrite_i,
    output logic       ex_hit_o,
    output logic       mem_hit_o,
    output logic       load_use_o
);

    logic ex_wr_valid;
    logic mem_wr_valid;

    assign ex_wr_valid  = ex_regwrite_i  && (ex_rd_i  != 5'd0);
    assign mem_wr_valid = mem_regwrite_i && (mem_rd_i != 5'd0);

    assign ex_hit_o  = ex_wr_valid &&
                       ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                        (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    assign mem_hit_o = mem_wr_valid &&
                       ((id_use_rs1_i && (id_rs1_i == mem_rd_i)) ||
                        (id_use_rs2_i && (id_rs2_i == mem_rd_i)));

    assign load_use_o = ex_hit_o && ex_memread_i;

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the five-stage RISC-V-lite pipeline.
// Produces stage enables, flush strobes and EX forward selects; holds the
// pipeline frozen and flushed for RST_HOLD cycles after reset.
//
// Build option: define PIPE_CTRL_FORWARDING_EN to enable operand forwarding.
// Without it, forward selects are 00 and ID stalls on any EX/MEM producer.
//
// Ports:
//   clk, rst (async, active-high)
//   id_rs1/2, id_use_rs1/2               : ID sources
//   ex_rs1/2, ex_rd, ex_regwrite, ex_memread : EX instruction
//   mem_rd, mem_regwrite, wb_rd, wb_regwrite : MEM and WB producers
//   br_taken                              : taken branch/jump sitting in MEM
//   dmem_req, dmem_ready                  : data-memory handshake
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en : stage enables
//   ifid_flush, idex_flush, exmem_flush   : stage-register clears
//   forwardA, forwardB                    : 00 none, 01 MEM/WB, 10 EX/MEM
//   stall_cycles, flush_events            : saturating performance counters
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RST_HOLD = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    ctrl_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  stall_q, flush_q;

    logic ex_hit, mem_hit, load_use;
    logic id_stall;
    logic mem_wait;
    logic hold_done;
    logic br_act;

    hazard_detect u_hazard_detect (
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .ex_rd_i        (ex_rd),
        .ex_regwrite_i  (ex_regwrite),
        .ex_memread_i   (ex_memread),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .ex_hit_o       (ex_hit),
        .mem_hit_o      (mem_hit),
        .load_use_o     (load_use)
    );

`ifdef PIPE_CTRL_FORWARDING_EN
    logic unused_fwd;
    assign unused_fwd = ex_hit ^ mem_hit;

    // Only a load result cannot be forwarded in time.
    assign id_stall = load_use;
    assign forwardA = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign forwardB = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{load_use, ex_rs1, ex_rs2, wb_rd, wb_regwrite};

    // WB producers are covered by the write-through register file.
    assign id_stall = ex_hit || mem_hit;
    assign forwardA = FWD_NONE;
    assign forwardB = FWD_NONE;
`endif

    assign mem_wait  = dmem_req && !dmem_ready;
    assign hold_done = (RST_HOLD <= 1) || (hold_cnt_q == HOLD_W'(RST_HOLD - 1));

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        br_act      = 1'b0;

        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    // Whole pipeline frozen; a pending branch stays in EX/MEM.
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    state_d  = MEM_WAIT;
                end else begin
                    state_d = RUN;
                    if (br_taken) begin
                        // The flush kills the ID instruction, so any ID hazard is moot.
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        br_act      = 1'b1;
                    end else if (id_stall) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
            default: begin
                // HOLD (and any illegal encoding): frozen and flushed.
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_en    = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                if (state_q != HOLD) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else if (hold_done) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            if (!pc_en && (state_q != HOLD) && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (br_act && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. Each stimulus cycle pushes its hand-worked
// expected outputs into a scoreboard queue; a monitor on the falling edge pops
// and compares them against the DUT outputs of that cycle.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [4:0] EN_ALL   = 5'b11111;
    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_STALL = 5'b00111;
    localparam logic [2:0] FL_ALL   = 3'b111;
    localparam logic [2:0] FL_NONE  = 3'b000;
    localparam logic [2:0] FL_BUB   = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
    logic        mem_regwrite, wb_regwrite, br_taken, dmem_req, dmem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  forwardA, forwardB;
    logic [15:0] stall_cycles, flush_events;

    pipeline_ctrl #(.RST_HOLD(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .forwardA(forwardA), .forwardB(forwardB),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [4:0] en;
        logic [2:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        int         s;
        int         f;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: compare whatever cycle the stimulus has queued.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.nm, " enables"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(e.en));
            check({e.nm, " flushes"}, 32'({ifid_flush, idex_flush, exmem_flush}), 32'(e.fl));
            check({e.nm, " forwardA"}, 32'(forwardA), 32'(e.fa));
            check({e.nm, " forwardB"}, 32'(forwardB), 32'(e.fb));
            check({e.nm, " stall_cycles"}, 32'(stall_cycles), 32'(e.s));
            check({e.nm, " flush_events"}, 32'(flush_events), 32'(e.f));
        end
    end

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
        br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Queue the expectation for the cycle whose inputs are already driven.
    task automatic cyc(input string nm, input logic [4:0] en, input logic [2:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input int s, input int f);
        exp_t e;
        e.nm = nm; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.s = s; e.f = f;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Stall counts differ by build: without forwarding the MEM match also stalls.
    localparam int SA = FWD ? 1 : 2;   // after load-use sequence
    localparam int SB = SA + 3;        // after the memory wait
    localparam int SC = FWD ? SB : SB + 2;  // after the ALU-dependency sequence

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        cyc("reset", EN_NONE, FL_ALL, 2'b00, 2'b00, 0, 0);

        rst = 1'b0;
        cyc("hold1", EN_NONE, FL_ALL, 2'b00, 2'b00, 0, 0);
        cyc("hold2", EN_NONE, FL_ALL, 2'b00, 2'b00, 0, 0);
        cyc("run_idle", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0);

        // lw x5 in EX, add x6,x5,x1 in ID
        ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        cyc("load_use", EN_STALL, FL_BUB, 2'b00, 2'b00, 0, 0);

        // bubble in EX, lw in MEM, add still in ID
        clear_inputs();
        mem_rd = 5'd5; mem_regwrite = 1'b1;
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        cyc("after_bubble", FWD ? EN_ALL : EN_STALL, FWD ? FL_NONE : FL_BUB, 2'b00, 2'b00, 1, 0);

        // add in EX, lw in WB
        clear_inputs();
        ex_rs1 = 5'd5; ex_rs2 = 5'd1; ex_rd = 5'd6; ex_regwrite = 1'b1;
        wb_rd = 5'd5; wb_regwrite = 1'b1;
        cyc("fwd_wb_a", EN_ALL, FL_NONE, FWD ? 2'b01 : 2'b00, 2'b00, SA, 0);

        clear_inputs();
        ex_rs1 = 5'd3; ex_rs2 = 5'd7;
        mem_rd = 5'd7; mem_regwrite = 1'b1; wb_rd = 5'd7; wb_regwrite = 1'b1;
        cyc("fwd_both_b", EN_ALL, FL_NONE, 2'b00, FWD ? 2'b10 : 2'b00, SA, 0);

        mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        cyc("fwd_x0", EN_ALL, FL_NONE, 2'b00, 2'b00, SA, 0);

        ex_rs1 = 5'd9; ex_rs2 = 5'd4; mem_rd = 5'd4; wb_rd = 5'd9;
        cyc("fwd_mixed", EN_ALL, FL_NONE, FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00, SA, 0);

        ex_rs1 = 5'd4; ex_rs2 = 5'd0; mem_rd = 5'd4; mem_regwrite = 1'b0; wb_rd = 5'd4;
        cyc("fwd_mem_nowr", EN_ALL, FL_NONE, FWD ? 2'b01 : 2'b00, 2'b00, SA, 0);

        // taken branch with a simultaneous load-use condition
        clear_inputs();
        br_taken = 1'b1;
        ex_rd = 5'd8; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs1 = 5'd8; id_use_rs1 = 1'b1;
        cyc("branch_lu", EN_ALL, FL_ALL, 2'b00, 2'b00, SA, 0);

        clear_inputs();
        cyc("post_branch", EN_ALL, FL_NONE, 2'b00, 2'b00, SA, 1);

        // data-memory wait for three cycles with a pending branch
        dmem_req = 1'b1; br_taken = 1'b1;
        cyc("mem_wait1", EN_NONE, FL_NONE, 2'b00, 2'b00, SA, 1);
        cyc("mem_wait2", EN_NONE, FL_NONE, 2'b00, 2'b00, SA + 1, 1);
        cyc("mem_wait3", EN_NONE, FL_NONE, 2'b00, 2'b00, SA + 2, 1);
        dmem_ready = 1'b1;
        cyc("mem_done_br", EN_ALL, FL_ALL, 2'b00, 2'b00, SB, 1);

        clear_inputs();
        cyc("post_wait", EN_ALL, FL_NONE, 2'b00, 2'b00, SB, 2);

        // add x3 in EX, sub x4,x3,x3 in ID
        ex_rd = 5'd3; ex_regwrite = 1'b1;
        id_rs1 = 5'd3; id_rs2 = 5'd3; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        cyc("alu_dep_ex", FWD ? EN_ALL : EN_STALL, FWD ? FL_NONE : FL_BUB, 2'b00, 2'b00, SB, 2);

        clear_inputs();
        mem_rd = 5'd3; mem_regwrite = 1'b1;
        id_rs1 = 5'd3; id_rs2 = 5'd3; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        cyc("alu_dep_mem", FWD ? EN_ALL : EN_STALL, FWD ? FL_NONE : FL_BUB, 2'b00, 2'b00,
            FWD ? SB : SB + 1, 2);

        clear_inputs();
        ex_rs1 = 5'd3; ex_rs2 = 5'd3; ex_rd = 5'd4; ex_regwrite = 1'b1;
        wb_rd = 5'd3; wb_regwrite = 1'b1;
        cyc("alu_dep_go", EN_ALL, FL_NONE, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00, SC, 2);

        // unused source must not trigger a load-use stall
        clear_inputs();
        ex_rd = 5'd9; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs1 = 5'd1; id_rs2 = 5'd9; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        cyc("lu_unused_rs2", EN_ALL, FL_NONE, 2'b00, 2'b00, SC, 2);

        id_use_rs2 = 1'b1;
        cyc("lu_used_rs2", EN_STALL, FL_BUB, 2'b00, 2'b00, SC, 2);

        clear_inputs();
        cyc("post_lu", EN_ALL, FL_NONE, 2'b00, 2'b00, SC + 1, 2);

        // asynchronous reset mid-operation
        rst = 1'b1;
        cyc("mid_reset", EN_NONE, FL_ALL, 2'b00, 2'b00, 0, 0);
        rst = 1'b0;
        cyc("re_hold1", EN_NONE, FL_ALL, 2'b00, 2'b00, 0, 0);
        cyc("re_hold2", EN_NONE, FL_ALL, 2'b00, 2'b00, 0, 0);
        cyc("re_run", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0);

        // bounded drain of the scoreboard
        for (int i = 0; i < 5 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        check("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
